// File: rtl/psram_arbiter_pkg.sv
// psram_arb_pkg: shared types and constants for the two-port PSRAM arbiter.
// FSM state encoding, burst direction codes and the user-beat derivation.
package psram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    XFER  = 2'd2,
    DRAIN = 2'd3
  } arb_state_e;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  // Each user-side beat carries two PSRAM words.
  function automatic int beats_of(input int burst_len);
    return burst_len / 2;
  endfunction

endpackage

// File: rtl/psram_arbiter_if.sv
// psram_arbiter_if: controller-side and requester-side signals of the arbiter.
// modport master is the arbiter's view, modport slave is the environment's view.
interface psram_arbiter_if #(
  parameter int BIT_WIDTH = 16
);
  localparam int DW = 2 * BIT_WIDTH;

  // controller side
  logic          init_cable_complete;
  logic          ctrl_idle;
  logic          ram_en;
  logic          rw_ctrl;
  logic [31:0]   addr_in;
  logic [DW-1:0] ram_data_in;
  logic          ram_wr_valid;
  logic          ram_rd_valid;
  logic [DW-1:0] ram_data_out;

  // port 0
  logic          p0_req;
  logic          p0_rw;
  logic [31:0]   p0_addr;
  logic [DW-1:0] p0_wdata;
  logic          p0_ack;
  logic          p0_wr_valid;
  logic          p0_rd_valid;
  logic [DW-1:0] p0_rdata;
  logic          p0_done;

  // port 1
  logic          p1_req;
  logic          p1_rw;
  logic [31:0]   p1_addr;
  logic [DW-1:0] p1_wdata;
  logic          p1_ack;
  logic          p1_wr_valid;
  logic          p1_rd_valid;
  logic [DW-1:0] p1_rdata;
  logic          p1_done;

  // status
  logic          busy;
  logic          grant_id;
  logic          err;

  modport master (
    input  init_cable_complete, ctrl_idle, ram_wr_valid, ram_rd_valid, ram_data_out,
    input  p0_req, p0_rw, p0_addr, p0_wdata,
    input  p1_req, p1_rw, p1_addr, p1_wdata,
    output ram_en, rw_ctrl, addr_in, ram_data_in,
    output p0_ack, p0_wr_valid, p0_rd_valid, p0_rdata, p0_done,
    output p1_ack, p1_wr_valid, p1_rd_valid, p1_rdata, p1_done,
    output busy, grant_id, err
  );

  modport slave (
    output init_cable_complete, ctrl_idle, ram_wr_valid, ram_rd_valid, ram_data_out,
    output p0_req, p0_rw, p0_addr, p0_wdata,
    output p1_req, p1_rw, p1_addr, p1_wdata,
    input  ram_en, rw_ctrl, addr_in, ram_data_in,
    input  p0_ack, p0_wr_valid, p0_rd_valid, p0_rdata, p0_done,
    input  p1_ack, p1_wr_valid, p1_rd_valid, p1_rdata, p1_done,
    input  busy, grant_id, err
  );

endinterface

// File: rtl/psram_arbiter_rr_pick.sv
// psram_rr_pick: two-request round-robin selector (combinational).
// A lone request wins outright; on a tie the port that did not win last time wins.
module psram_rr_pick (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_id
);

  // Pick the winner from the current request pair and the previous grant.
  always_comb begin
    gnt_valid = |req;
    gnt_id    = 1'b0;
    case (req)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ~last_grant;
      default: gnt_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/psram_arbiter.sv
// psram_arbiter: two-port round-robin arbiter in front of psram_controller (ram_clk domain).
// Grants one port, issues one ram_en burst command, steers write/read beats to the owner
// with zero added latency and releases the controller once the burst has drained.
// Optional watchdog: define PSRAM_ARB_WDOG_EN to abort a stalled burst and set sticky err.
module psram_arbiter
  import psram_arb_pkg::*;
#(
  parameter int BIT_WIDTH   = 16,
  parameter int BURST_LEN   = 16,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic ram_clk,
  input  logic ram_rst,
  psram_arbiter_if.master bus
);

  localparam int                BEATS     = beats_of(BURST_LEN);
  localparam int                CNT_W     = $clog2(BEATS) + 1;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

  if ((BEATS < 2) || ((BEATS & (BEATS - 1)) != 0) || (WDOG_CYCLES < 2)) begin : g_bad_cfg
    $error("psram_arbiter: BURST_LEN/2 must be a power of 2 >= 2 and WDOG_CYCLES >= 2");
  end

  arb_state_e            state_r;
  logic [CNT_W-1:0]      beat_cnt_r;
  logic                  last_grant_r;
  logic                  ram_en_r;
  logic                  rw_ctrl_r;
  logic [31:0]           addr_in_r;
  logic                  p0_ack_r;
  logic                  p1_ack_r;
  logic                  p0_done_r;
  logic                  p1_done_r;
  logic                  busy_r;
  logic                  grant_id_r;

  logic [1:0]            req_s;
  logic                  pick_valid_s;
  logic                  pick_id_s;
  logic                  start_s;
  logic                  beat_s;
  logic                  wdog_hit_s;
  logic [2*BIT_WIDTH-1:0] wdata_sel_s;

  assign req_s   = {bus.p1_req, bus.p0_req};
  assign start_s = (state_r == IDLE) & bus.init_cable_complete & bus.ctrl_idle & pick_valid_s;

  psram_rr_pick u_pick (
    .req        (req_s),
    .last_grant (last_grant_r),
    .gnt_valid  (pick_valid_s),
    .gnt_id     (pick_id_s)
  );

  // A beat only counts when its direction matches the granted command.
  always_comb begin
    beat_s = 1'b0;
    if (rw_ctrl_r == RW_WRITE) begin
      beat_s = bus.ram_wr_valid;
    end else begin
      beat_s = bus.ram_rd_valid;
    end
  end

`ifdef PSRAM_ARB_WDOG_EN
  localparam int               WDOG_W     = $clog2(WDOG_CYCLES);
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(WDOG_CYCLES - 1);

  logic [WDOG_W-1:0] wdog_cnt_r;
  logic              err_r;
  logic              wdog_run_s;

  assign wdog_run_s = (state_r == XFER) | (state_r == DRAIN);
  assign wdog_hit_s = wdog_run_s & (wdog_cnt_r == WDOG_LIMIT);

  // Watchdog: restart on every grant, count while a burst is in flight, latch err on expiry.
  always_ff @(posedge ram_clk or negedge ram_rst) begin
    if (!ram_rst) begin
      wdog_cnt_r <= {WDOG_W{1'b0}};
      err_r      <= 1'b0;
    end else if (start_s) begin
      wdog_cnt_r <= {WDOG_W{1'b0}};
    end else if (wdog_hit_s) begin
      wdog_cnt_r <= {WDOG_W{1'b0}};
      err_r      <= 1'b1;
    end else if (wdog_run_s) begin
      wdog_cnt_r <= wdog_cnt_r + WDOG_W'(1);
    end else begin
      wdog_cnt_r <= wdog_cnt_r;
    end
  end

  assign bus.err = err_r;
`else
  assign wdog_hit_s = 1'b0;
  assign bus.err    = 1'b0;
`endif

  // Arbitration FSM; every command/handshake/status output is registered here.
  always_ff @(posedge ram_clk or negedge ram_rst) begin
    if (!ram_rst) begin
      state_r      <= IDLE;
      beat_cnt_r   <= {CNT_W{1'b0}};
      last_grant_r <= 1'b1;
      ram_en_r     <= 1'b0;
      rw_ctrl_r    <= 1'b0;
      addr_in_r    <= 32'h0000_0000;
      p0_ack_r     <= 1'b0;
      p1_ack_r     <= 1'b0;
      p0_done_r    <= 1'b0;
      p1_done_r    <= 1'b0;
      busy_r       <= 1'b0;
      grant_id_r   <= 1'b0;
    end else begin
      ram_en_r  <= 1'b0;
      p0_ack_r  <= 1'b0;
      p1_ack_r  <= 1'b0;
      p0_done_r <= 1'b0;
      p1_done_r <= 1'b0;
      if (wdog_hit_s) begin
        state_r    <= IDLE;
        beat_cnt_r <= {CNT_W{1'b0}};
        busy_r     <= 1'b0;
        p0_done_r  <= ~grant_id_r;
        p1_done_r  <= grant_id_r;
      end else begin
        case (state_r)
          IDLE: begin
            if (start_s) begin
              grant_id_r   <= pick_id_s;
              last_grant_r <= pick_id_s;
              rw_ctrl_r    <= pick_id_s ? bus.p1_rw : bus.p0_rw;
              addr_in_r    <= pick_id_s ? bus.p1_addr : bus.p0_addr;
              ram_en_r     <= 1'b1;
              p0_ack_r     <= ~pick_id_s;
              p1_ack_r     <= pick_id_s;
              busy_r       <= 1'b1;
              state_r      <= ISSUE;
            end else begin
              state_r <= IDLE;
            end
          end
          ISSUE: begin
            state_r <= XFER;
          end
          XFER: begin
            if (beat_s) begin
              beat_cnt_r <= beat_cnt_r + CNT_W'(1);
              if (beat_cnt_r == LAST_BEAT) begin
                state_r <= DRAIN;
              end else begin
                state_r <= XFER;
              end
            end else begin
              state_r <= XFER;
            end
          end
          DRAIN: begin
            if (bus.ctrl_idle) begin
              beat_cnt_r <= {CNT_W{1'b0}};
              busy_r     <= 1'b0;
              p0_done_r  <= ~grant_id_r;
              p1_done_r  <= grant_id_r;
              state_r    <= IDLE;
            end else begin
              state_r <= DRAIN;
            end
          end
          default: begin
            state_r    <= IDLE;
            beat_cnt_r <= {CNT_W{1'b0}};
            busy_r     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.ram_en   = ram_en_r;
  assign bus.rw_ctrl  = rw_ctrl_r;
  assign bus.addr_in  = addr_in_r;
  assign bus.p0_ack   = p0_ack_r;
  assign bus.p1_ack   = p1_ack_r;
  assign bus.p0_done  = p0_done_r;
  assign bus.p1_done  = p1_done_r;
  assign bus.busy     = busy_r;
  assign bus.grant_id = grant_id_r;

  // Data steering: owner's write data goes out (port 0 when idle), read data is broadcast.
  assign wdata_sel_s     = (busy_r && grant_id_r) ? bus.p1_wdata : bus.p0_wdata;
  assign bus.ram_data_in = wdata_sel_s;
  assign bus.p0_rdata    = bus.ram_data_out;
  assign bus.p1_rdata    = bus.ram_data_out;

  assign bus.p0_wr_valid = bus.ram_wr_valid & busy_r & ~grant_id_r & (rw_ctrl_r == RW_WRITE);
  assign bus.p1_wr_valid = bus.ram_wr_valid & busy_r &  grant_id_r & (rw_ctrl_r == RW_WRITE);
  assign bus.p0_rd_valid = bus.ram_rd_valid & busy_r & ~grant_id_r & (rw_ctrl_r == RW_READ);
  assign bus.p1_rd_valid = bus.ram_rd_valid & busy_r &  grant_id_r & (rw_ctrl_r == RW_READ);

endmodule

// File: tb/tb_psram_arbiter.sv
// tb_psram_arbiter: directed + randomized bench for psram_arbiter with a behavioural
// controller/requester model. Exercises PSRAM_ARB_WDOG_EN only when that macro is defined.
module tb_psram_arbiter;

  localparam int BW    = 16;
  localparam int DW    = 2 * BW;
  localparam int NBEAT = 8;   // BURST_LEN 16 -> 8 user beats

  logic ram_clk = 1'b0;
  logic ram_rst = 1'b0;

  int checks = 0;
  int errors = 0;

  // requester-side view kept by the bench
  bit            req_b   [2];
  bit            rw_b    [2];
  logic [31:0]   addr_b  [2];
  logic [DW-1:0] wdata_b [2];
  bit            lg;      // port that won the last arbitration

  psram_arbiter_if #(.BIT_WIDTH(BW)) bus ();

  psram_arbiter #(
    .BIT_WIDTH   (BW),
    .BURST_LEN   (16),
    .WDOG_CYCLES (64)
  ) dut (
    .ram_clk (ram_clk),
    .ram_rst (ram_rst),
    .bus     (bus)
  );

  always #5 ram_clk = ~ram_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs_zero(input string tag);
    chk(tag, {bus.ram_en, bus.rw_ctrl, bus.addr_in, bus.p0_ack, bus.p1_ack,
              bus.p0_done, bus.p1_done, bus.busy, bus.grant_id, bus.err}, 64'd0);
  endtask

  task automatic drive_ports();
    bus.p0_req   = req_b[0];
    bus.p0_rw    = rw_b[0];
    bus.p0_addr  = addr_b[0];
    bus.p0_wdata = wdata_b[0];
    bus.p1_req   = req_b[1];
    bus.p1_rw    = rw_b[1];
    bus.p1_addr  = addr_b[1];
    bus.p1_wdata = wdata_b[1];
  endtask

  // Round-robin rule: a lone requester wins; on a tie the previous loser wins.
  function automatic bit rr_win(input bit r0, input bit r1, input bit last);
    if (r0 && r1) return !last;
    return r1;
  endfunction

  function automatic logic [1:0] onehot(input bit port);
    return port ? 2'b10 : 2'b01;
  endfunction

  // Wait for the command strobe, check it, optionally re-raise the other port's request.
  task automatic start_burst(input bit port, input int max_wait, input bit reraise, output bit seen);
    seen = 1'b0;
    for (int w = 0; w <= max_wait; w++) begin
      if (w > 0) @(negedge ram_clk);
      if (bus.ram_en === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("cmd_seen", seen, 1);
    if (!seen) return;
    chk("ack", {bus.p1_ack, bus.p0_ack}, onehot(port));
    chk("grant_id", bus.grant_id, port);
    chk("rw_ctrl", bus.rw_ctrl, rw_b[port]);
    chk("addr_in", bus.addr_in, addr_b[port]);
    chk("busy_issue", bus.busy, 1);
    if (reraise && !req_b[!port]) begin
      rw_b[!port]   = 1'($urandom_range(0, 1));
      addr_b[!port] = $urandom;
      req_b[!port]  = 1'b1;
    end
    drive_ports();
    @(negedge ram_clk);
    chk("ram_en_one_cycle", {bus.ram_en, bus.p1_ack, bus.p0_ack}, 3'd0);
  endtask

  // One user beat from the controller, preceded by 0..2 idle cycles that may carry a
  // wrong-direction strobe which must not be forwarded.
  task automatic one_beat(input bit port, input bit rw);
    int gap;
    logic [DW-1:0] rd_val;
    gap = $urandom_range(0, 2);
    repeat (gap) begin
      @(negedge ram_clk);
      bus.ram_wr_valid = 1'b0;
      bus.ram_rd_valid = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        if (rw) bus.ram_rd_valid = 1'b1;
        else    bus.ram_wr_valid = 1'b1;
      end
      #1;
      chk("stray_not_fwd", {bus.p0_wr_valid, bus.p1_wr_valid, bus.p0_rd_valid, bus.p1_rd_valid}, 4'd0);
    end
    @(negedge ram_clk);
    rd_val            = $urandom;
    bus.ram_data_out  = rd_val;
    bus.ram_wr_valid  = rw;
    bus.ram_rd_valid  = !rw;
    #1;
    chk("early_done", {bus.p1_done, bus.p0_done}, 2'd0);
    if (rw) begin
      chk("wr_valid", {bus.p1_wr_valid, bus.p0_wr_valid}, onehot(port));
      chk("rd_quiet", {bus.p1_rd_valid, bus.p0_rd_valid}, 2'd0);
      chk("wr_data", bus.ram_data_in, wdata_b[port]);
      wdata_b[port] = $urandom;
      drive_ports();
    end else begin
      chk("rd_valid", {bus.p1_rd_valid, bus.p0_rd_valid}, onehot(port));
      chk("wr_quiet", {bus.p1_wr_valid, bus.p0_wr_valid}, 2'd0);
      chk("rd_data", port ? bus.p1_rdata : bus.p0_rdata, rd_val);
    end
  endtask

  // Stop strobes, hold the controller busy, then release it and expect the done pulse.
  task automatic finish_burst(input bit port);
    bit seen;
    @(negedge ram_clk);
    bus.ram_wr_valid = 1'b0;
    bus.ram_rd_valid = 1'b0;
    repeat (2) begin
      @(negedge ram_clk);
      chk("drain_wait", {bus.busy, bus.p1_done, bus.p0_done}, 3'b100);
    end
    bus.ctrl_idle = 1'b1;
    seen = 1'b0;
    for (int w = 0; w < 4 && !seen; w++) begin
      @(negedge ram_clk);
      seen = bus.p0_done | bus.p1_done;
    end
    chk("done_seen", seen, 1);
    chk("done_port", {bus.p1_done, bus.p0_done}, onehot(port));
    chk("busy_after", bus.busy, 0);
    chk("rw_hold", bus.rw_ctrl, rw_b[port]);
    chk("addr_hold", bus.addr_in, addr_b[port]);
    req_b[port] = 1'b0;
    drive_ports();
    lg = port;
  endtask

  task automatic do_burst(input bit port, input int max_wait, input bit reraise);
    bit seen;
    bit rw;
    rw = rw_b[port];
    start_burst(port, max_wait, reraise, seen);
    if (!seen) begin
      req_b[port] = 1'b0;
      drive_ports();
      return;
    end
    for (int i = 0; i < NBEAT; i++) begin
      if (i == NBEAT - 1) bus.ctrl_idle = 1'b0;
      one_beat(port, rw);
    end
    finish_burst(port);
  endtask

  initial begin
    bit exp_port;
    bit seen;
    int cyc;

    lg = 1'b1;
    for (int p = 0; p < 2; p++) begin
      req_b[p]   = 1'b0;
      rw_b[p]    = 1'b0;
      addr_b[p]  = 32'h0;
      wdata_b[p] = $urandom;
    end
    drive_ports();
    bus.init_cable_complete = 1'b0;
    bus.ctrl_idle           = 1'b0;
    bus.ram_wr_valid        = 1'b0;
    bus.ram_rd_valid        = 1'b0;
    bus.ram_data_out        = '0;

    repeat (3) @(negedge ram_clk);
    chk_regs_zero("reset_state");
    ram_rst = 1'b1;

    // Port 0 write at 0x4 held back until calibration done and controller idle.
    req_b[0] = 1'b1; rw_b[0] = 1'b1; addr_b[0] = 32'h4;
    drive_ports();
    bus.ctrl_idle = 1'b1;
    repeat (4) begin
      @(negedge ram_clk);
      chk("gate_init", {bus.ram_en, bus.p0_ack, bus.busy}, 3'd0);
    end
    bus.init_cable_complete = 1'b1;
    bus.ctrl_idle           = 1'b0;
    repeat (3) begin
      @(negedge ram_clk);
      chk("gate_idle", {bus.ram_en, bus.p0_ack, bus.busy}, 3'd0);
    end
    bus.ctrl_idle = 1'b1;
    do_burst(rr_win(req_b[0], req_b[1], lg), 1, 1'b0);

    // Port 1 read at 0x100 with port 0 quiet.
    req_b[1] = 1'b1; rw_b[1] = 1'b0; addr_b[1] = 32'h100;
    drive_ports();
    do_burst(rr_win(req_b[0], req_b[1], lg), 3, 1'b0);

    // Both ports contend repeatedly: grants must alternate.
    for (int p = 0; p < 2; p++) begin
      req_b[p]  = 1'b1;
      rw_b[p]   = 1'($urandom_range(0, 1));
      addr_b[p] = $urandom;
    end
    drive_ports();
    for (int k = 0; k < 4; k++) begin
      exp_port = rr_win(req_b[0], req_b[1], lg);
      chk("rr_alternate", exp_port, k[0]);
      do_burst(exp_port, 3, k < 3);
    end

    // Reset asserted during the 4th beat of a write burst.
    req_b[0] = 1'b1; rw_b[0] = 1'b1; addr_b[0] = $urandom;
    drive_ports();
    start_burst(rr_win(req_b[0], req_b[1], lg), 3, 1'b0, seen);
    for (int i = 0; i < 3; i++) one_beat(1'b0, 1'b1);
    @(negedge ram_clk);
    bus.ram_wr_valid = 1'b1;
    #1;
    ram_rst = 1'b0;
    #1;
    chk_regs_zero("reset_mid_burst");
    chk("reset_fwd", {bus.p0_wr_valid, bus.p1_wr_valid, bus.p0_rd_valid, bus.p1_rd_valid}, 4'd0);
    bus.ram_wr_valid = 1'b0;
    lg = 1'b1;
    repeat (2) @(negedge ram_clk);
    ram_rst       = 1'b1;
    bus.ctrl_idle = 1'b1;
    do_burst(rr_win(req_b[0], req_b[1], lg), 3, 1'b0);

`ifdef PSRAM_ARB_WDOG_EN
    // Controller stalls after 3 beats: watchdog aborts the burst.
    req_b[0] = 1'b1; rw_b[0] = 1'b1; addr_b[0] = 32'h40;
    drive_ports();
    start_burst(rr_win(req_b[0], req_b[1], lg), 3, 1'b0, seen);
    for (int i = 0; i < 3; i++) one_beat(1'b0, 1'b1);
    @(negedge ram_clk);
    bus.ram_wr_valid = 1'b0;
    bus.ctrl_idle    = 1'b0;
    chk("err_before", bus.err, 0);
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 200) begin
      @(negedge ram_clk);
      cyc++;
      seen = bus.p0_done;
    end
    chk("wdog_done", seen, 1);
    chk("wdog_err", bus.err, 1);
    chk("wdog_idle", bus.busy, 0);
    req_b[0] = 1'b0;
    drive_ports();
    bus.ctrl_idle = 1'b1;
    repeat (3) @(negedge ram_clk);
    chk("err_sticky", bus.err, 1);
`else
    chk("err_tied", bus.err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
